port_out_uart_tx: RTL and testbench
===================================

Name: port_out_uart_tx

Overview:
- Downstream consumer of the CPU output port. It captures each byte the CPU writes to port_out into a small FIFO.
- It serializes buffered bytes onto a UART-style line: 8N1, LSB first.
- It decouples single-cycle CPU port writes from the slow serial line, flags dropped bytes, and exposes fill status for polling through port_in.

Parameters:
- DATA_BITS, 8, width of one port byte / serial data bits per frame.
- FIFO_DEPTH, 4, FIFO entries; power of 2, minimum 2.
- CLKS_PER_BIT, 16, clock cycles per serial bit; minimum 2.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (reset=0 resets).
- port_wr  in  1  one-cycle strobe: CPU writes port_data this cycle.
- port_data  in  DATA_BITS  byte from CPU port_out.
- ovf_clear  in  1  clears sticky overflow flag.
- tx  out  1  serial output, idle high.
- full  out  1  FIFO level == FIFO_DEPTH.
- empty  out  1  FIFO level == 0.
- level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- busy  out  1  high while a frame is on the line (FSM != IDLE).
- overflow  out  1  sticky: a write was dropped.

Behaviour:
- Reset (async assert, sync-released use): tx=1, full=0, empty=1, level=0, busy=0, overflow=0. FIFO pointers=0, FSM=IDLE, bit timer=0, bit index=0. Reset mid-frame aborts the frame immediately: tx returns high, queued bytes are discarded.
- FIFO: circular buffer with read/write pointers and a separate level counter; pointers wrap modulo FIFO_DEPTH. full, empty and level are registered and consistent with each other every cycle.
- Push: accepted at a rising edge when port_wr=1 and (full=0 or a pop occurs at the same edge). Otherwise the byte is dropped, FIFO is unchanged, and overflow is set at that edge.
- Pop: occurs at an edge where the FSM is in IDLE with empty=0, or in STOP on its last cycle with empty=0. The popped byte loads the shift register.
- Simultaneous push+pop: level unchanged, both pointers advance. Push+pop at full succeeds.
- overflow: set by a dropped write, cleared by ovf_clear=1. If both happen in the same cycle, set wins.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. On pop -> START.
  - START: tx=0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, shifting right after each bit. After DATA_BITS bits -> STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. On the last cycle: pop -> START (no idle gap between frames), else -> IDLE.
- Bit timer counts 0..CLKS_PER_BIT-1 and resets on every state/bit transition.
- Frame length: exactly (DATA_BITS+2)*CLKS_PER_BIT cycles.
- tx is driven from a register (glitch-free).
- Latency: write sampled at edge k into an empty FIFO with the FSM idle. empty=0 after edge k; pop at edge k+1; tx=0 and busy=1 after edge k+1.
- busy=1 from START entry until the STOP->IDLE transition.
- port_data is sampled only on an accepted push; later changes do not affect queued bytes.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset asserted, then released -> tx=1, empty=1, full=0, level=0, busy=0, overflow=0.
- Single write 0x0A at edge k -> tx low edges k+1..k+4. Then data bits 0,1,0,1,0,0,0,0, each 4 cycles. Then stop high 4 cycles. busy high exactly 40 cycles. level returns 0 after edge k+1.
- 7 consecutive writes 0x01..0x07 starting on an idle, empty FIFO -> 0x01..0x05 accepted, 0x06 and 0x07 dropped. full=1 after the 0x05 write, overflow=1. Line emits 01,02,03,04,05 as 5 contiguous 40-cycle frames with no idle gap.
- FIFO full while a frame's STOP last cycle pops, with port_wr=1 (0x5A) at that same edge -> write accepted, overflow stays 0, level stays 4. 0x5A is transmitted last.
- Reset asserted mid-DATA of frame 0x3C with 2 bytes queued -> tx=1, level=0, busy=0 immediately. After release, no further frames are emitted.
- overflow=1, then ovf_clear=1 in the same cycle as a dropped write -> overflow stays 1. ovf_clear=1 alone on the next cycle -> overflow=0.

Source files
------------

// File: rtl/port_out_uart_tx.sv
// port_out_uart_tx: buffers bytes written to the CPU output port in a small
// FIFO and transmits them as 8N1 UART frames, LSB first. The tx line idles high.
// The block reports FIFO fill status and a sticky flag for dropped writes.
module port_out_uart_tx #(
   parameter int DATA_BITS    = 8,
   parameter int FIFO_DEPTH   = 4,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          port_wr,
   input  logic [DATA_BITS-1:0]          port_data,
   input  logic                          ovf_clear,
   output logic                          tx,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          busy,
   output logic                          overflow
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int TMR_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
   localparam logic [PTR_W:0]   LVL_FULL  = (PTR_W + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                 state_reg, state_next;
   logic [TMR_W-1:0]       timer_reg, timer_next;
   logic [IDX_W-1:0]       bit_idx_reg, bit_idx_next;
   logic [DATA_BITS-1:0]   shift_reg, shift_next;
   logic                   tx_reg, tx_next;

   logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_ptr_reg, rd_ptr_reg;
   logic [PTR_W:0]         level_reg, level_next;
   logic                   full_reg, empty_reg, overflow_reg;

   logic                   pop, push, drop, bit_end;

   // A write is taken when there is room, or when a pop frees a slot at the same edge.
   assign push    = port_wr && (!full_reg || pop);
   assign drop    = port_wr && !push;
   assign bit_end = (timer_reg == TMR_LAST);

   // Frame sequencer: next state, bit timing, shifter and next line level.
   always_comb begin
      state_next   = state_reg;
      timer_next   = timer_reg;
      bit_idx_next = bit_idx_reg;
      shift_next   = shift_reg;
      tx_next      = tx_reg;
      pop          = 1'b0;
      case (state_reg)
         IDLE: begin
            tx_next    = 1'b1;
            timer_next = '0;
            if (!empty_reg) begin
               pop        = 1'b1;
               shift_next = mem[rd_ptr_reg];
               state_next = START;
               tx_next    = 1'b0;
            end
         end
         START: begin
            if (bit_end) begin
               state_next   = DATA;
               timer_next   = '0;
               bit_idx_next = '0;
               tx_next      = shift_reg[0];
            end else begin
               timer_next = timer_reg + 1'b1;
            end
         end
         DATA: begin
            if (bit_end) begin
               timer_next = '0;
               shift_next = shift_reg >> 1;
               if (bit_idx_reg == IDX_LAST) begin
                  state_next = STOP;
                  tx_next    = 1'b1;
               end else begin
                  bit_idx_next = bit_idx_reg + 1'b1;
                  tx_next      = shift_next[0];
               end
            end else begin
               timer_next = timer_reg + 1'b1;
            end
         end
         STOP: begin
            if (bit_end) begin
               timer_next = '0;
               // Chain straight into the next frame when a byte is waiting.
               if (!empty_reg) begin
                  pop        = 1'b1;
                  shift_next = mem[rd_ptr_reg];
                  state_next = START;
                  tx_next    = 1'b0;
               end else begin
                  state_next = IDLE;
                  tx_next    = 1'b1;
               end
            end else begin
               timer_next = timer_reg + 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            tx_next    = 1'b1;
            timer_next = '0;
         end
      endcase
   end

   // Occupancy after this edge's push/pop.
   always_comb begin
      level_next = level_reg;
      if (push && !pop) begin
         level_next = level_reg + 1'b1;
      end else if (pop && !push) begin
         level_next = level_reg - 1'b1;
      end
   end

   // Sequencer state; an asserted reset aborts a frame and forces the line high.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg   <= IDLE;
         timer_reg   <= '0;
         bit_idx_reg <= '0;
         shift_reg   <= '0;
         tx_reg      <= 1'b1;
      end else begin
         state_reg   <= state_next;
         timer_reg   <= timer_next;
         bit_idx_reg <= bit_idx_next;
         shift_reg   <= shift_next;
         tx_reg      <= tx_next;
      end
   end

   // FIFO bookkeeping. full/empty are registered from the next level, so they always agree with level.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         level_reg    <= '0;
         full_reg     <= 1'b0;
         empty_reg    <= 1'b1;
         overflow_reg <= 1'b0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         level_reg <= level_next;
         full_reg  <= (level_next == LVL_FULL);
         empty_reg <= (level_next == '0);
         if (drop) begin
            overflow_reg <= 1'b1;
         end else if (ovf_clear) begin
            overflow_reg <= 1'b0;
         end
      end
   end

   // FIFO storage. The array has no reset; reset discards contents by clearing the pointers.
   // The read is combinational so a popped byte reaches the shifter on the same edge.
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr_reg] <= port_data;
   end

   assign tx       = tx_reg;
   assign full     = full_reg;
   assign empty    = empty_reg;
   assign level    = level_reg;
   assign busy     = (state_reg != IDLE);
   assign overflow = overflow_reg;

endmodule

// File: tb/tb_port_out_uart_tx.sv
// tb_port_out_uart_tx: directed tests for port_out_uart_tx with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
// A line monitor decodes each frame, checks its exact shape and records when it started.
module tb_port_out_uart_tx;

   localparam int CPB   = 4;
   localparam int FRAME = 40;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       port_wr = 1'b0;
   logic [7:0] port_data = 8'h00;
   logic       ovf_clear = 1'b0;
   logic       tx, full, empty, busy, overflow;
   logic [2:0] level;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [7:0] rx_q [$];
   logic [7:0] exp_q [$];
   int         start_q [$];

   port_out_uart_tx #(
      .DATA_BITS(8),
      .FIFO_DEPTH(4),
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clock(clock),
      .reset(reset),
      .port_wr(port_wr),
      .port_data(port_data),
      .ovf_clear(ovf_clear),
      .tx(tx),
      .full(full),
      .empty(empty),
      .level(level),
      .busy(busy),
      .overflow(overflow)
   );

   always #5 clock = ~clock;

   // cycle number = count of rising edges so far
   initial forever begin
      @(posedge clock);
      cyc++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Line monitor: samples tx once per cycle and decodes frames.
   logic [39:0] rx_bits;
   logic [39:0] exp_frame;
   logic [7:0]  rx_byte;
   int          rx_cnt;
   int          rx_start;
   bit          rx_active = 1'b0;

   initial forever begin
      @(negedge clock);
      if (!reset) begin
         rx_active = 1'b0;
      end else if (!rx_active) begin
         if (tx == 1'b0) begin
            rx_active = 1'b1;
            rx_cnt    = 1;
            rx_bits   = '0;
            rx_start  = cyc;
         end
      end else begin
         rx_bits[rx_cnt] = tx;
         if (rx_cnt == FRAME - 1) begin
            rx_active = 1'b0;
            for (int i = 0; i < 8; i++) rx_byte[i] = rx_bits[CPB + CPB*i + 2];
            exp_frame = '0;
            for (int i = 0; i < 8; i++)
               for (int j = 0; j < CPB; j++) exp_frame[CPB + CPB*i + j] = rx_byte[i];
            for (int j = 36; j < 40; j++) exp_frame[j] = 1'b1;
            check_value("frame_shape", {24'b0, rx_bits}, {24'b0, exp_frame});
            rx_q.push_back(rx_byte);
            start_q.push_back(rx_start);
            $display("rx frame %02h start cycle %0d", rx_byte, rx_start);
         end else begin
            rx_cnt++;
         end
      end
   end

   task automatic wait_idle(input int max_cycles);
      int n = 0;
      while ((busy || !empty) && n < max_cycles) begin
         @(negedge clock);
         n++;
      end
      check_value("idle_timeout", {63'b0, busy | ~empty}, 64'd0);
   endtask

   task automatic drain(input string tag, input int first_start, input bit contiguous);
      check_value({tag, "_count"}, rx_q.size(), exp_q.size());
      if (first_start >= 0 && start_q.size() > 0)
         check_value({tag, "_first_start"}, start_q[0], first_start);
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
         check_value({tag, "_byte"}, rx_q[i], exp_q[i]);
         if (contiguous && i > 0)
            check_value({tag, "_gap"}, start_q[i] - start_q[i-1], FRAME);
      end
      rx_q.delete();
      start_q.delete();
      exp_q.delete();
   endtask

   task automatic check_reset_state(input string tag);
      check_value({tag, "_tx"}, tx, 1);
      check_value({tag, "_empty"}, empty, 1);
      check_value({tag, "_full"}, full, 0);
      check_value({tag, "_level"}, level, 0);
      check_value({tag, "_busy"}, busy, 0);
      check_value({tag, "_overflow"}, overflow, 0);
   endtask

   initial begin
      int k;
      int s;
      int busy_cnt;
      int low_cnt;

      // Reset held, then released
      repeat (3) @(negedge clock);
      check_reset_state("in_reset");
      reset = 1'b1;
      repeat (2) @(negedge clock);
      check_reset_state("after_reset");

      // Single write 0x0A: latency, frame and busy duration
      k = cyc + 1;
      port_wr = 1'b1; port_data = 8'h0A;
      @(negedge clock);
      port_wr = 1'b0; port_data = 8'hFF;
      check_value("lat_empty", empty, 0);
      check_value("lat_level", level, 1);
      check_value("lat_busy0", busy, 0);
      check_value("lat_tx1", tx, 1);
      @(negedge clock);
      check_value("lat_tx0", tx, 0);
      check_value("lat_busy1", busy, 1);
      check_value("lat_level0", level, 0);
      busy_cnt = 1;
      for (int i = 0; i < 59; i++) begin
         @(negedge clock);
         if (busy) busy_cnt++;
      end
      check_value("busy_cycles", busy_cnt, FRAME);
      exp_q.push_back(8'h0A);
      drain("single", k + 1, 1'b0);

      // Seven back-to-back writes: two dropped, five contiguous frames
      k = cyc + 1;
      for (int i = 0; i < 7; i++) begin
         port_wr = 1'b1; port_data = 8'(i + 1);
         @(negedge clock);
         if (i == 4) check_value("burst_full", full, 1);
      end
      port_wr = 1'b0;
      check_value("burst_overflow", overflow, 1);
      check_value("burst_level", level, 4);
      // Clear together with a dropped write: set wins
      port_wr = 1'b1; port_data = 8'h99; ovf_clear = 1'b1;
      @(negedge clock);
      port_wr = 1'b0;
      check_value("ovf_set_wins", overflow, 1);
      check_value("ovf_level", level, 4);
      @(negedge clock);
      ovf_clear = 1'b0;
      check_value("ovf_cleared", overflow, 0);
      for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
      wait_idle(400);
      drain("burst", k + 1, 1'b1);

      // Write at full on the edge where the STOP last cycle pops
      k = cyc + 1;
      port_wr = 1'b1; port_data = 8'h11;
      @(negedge clock);
      port_data = 8'h22; @(negedge clock);
      port_data = 8'h33; @(negedge clock);
      port_data = 8'h44; @(negedge clock);
      port_data = 8'h55; @(negedge clock);
      port_wr = 1'b0;
      check_value("pp_full", full, 1);
      check_value("pp_level", level, 4);
      s = k + 1;
      while (cyc < s + FRAME - 1) @(negedge clock);
      port_wr = 1'b1; port_data = 8'h5A;
      @(negedge clock);
      port_wr = 1'b0; port_data = 8'h00;
      check_value("pp_level_after", level, 4);
      check_value("pp_full_after", full, 1);
      check_value("pp_overflow", overflow, 0);
      check_value("pp_next_start", tx, 0);
      exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
      exp_q.push_back(8'h44); exp_q.push_back(8'h55); exp_q.push_back(8'h5A);
      wait_idle(400);
      drain("pushpop", s, 1'b1);

      // Reset in the middle of the data bits of 0x3C with two bytes queued
      k = cyc + 1;
      port_wr = 1'b1; port_data = 8'h3C; @(negedge clock);
      port_data = 8'h77; @(negedge clock);
      port_data = 8'h88; @(negedge clock);
      port_wr = 1'b0;
      check_value("mid_level", level, 2);
      while (cyc < k + 1 + 12) @(negedge clock);
      check_value("mid_busy", busy, 1);
      #1 reset = 1'b0;
      #1;
      check_value("abort_tx", tx, 1);
      check_value("abort_level", level, 0);
      check_value("abort_busy", busy, 0);
      check_value("abort_empty", empty, 1);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      low_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         if (!tx) low_cnt++;
      end
      check_value("abort_no_tx", low_cnt, 0);
      check_value("abort_busy_after", busy, 0);
      check_value("abort_level_after", level, 0);
      drain("abort", -1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
